// File: rtl/hamming_tx_serial_if.sv
// rtl/hamming_tx_serial_if.sv - nibble handshake between sender and Hamming(7,4) serial transmitter
interface hamming_tx_serial_if;
    logic [3:0] dato_i;
    logic [2:0] error_pos_i;
    logic       valido_i;
    logic       listo_o;

    modport master (
        output dato_i,
        output error_pos_i,
        output valido_i,
        input  listo_o
    );

    modport slave (
        input  dato_i,
        input  error_pos_i,
        input  valido_i,
        output listo_o
    );
endinterface

// File: rtl/hamming_tx_serial.sv
// rtl/hamming_tx_serial.sv - Hamming(7,4) encoder with error injection and UART-style serial output
module hamming_tx_serial #(
    parameter int CICLOS_POR_BIT = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    hamming_tx_serial_if.slave  bus,
    output logic [6:0]          palabra_o,
    output logic                tx_o,
    output logic                ocupado_o,
    output logic                hecho_o
);
    localparam int BAUD_W = (CICLOS_POR_BIT > 1) ? $clog2(CICLOS_POR_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_ULT = BAUD_W'(CICLOS_POR_BIT - 1);

    typedef enum logic [1:0] {REPOSO, INICIO, DATOS, PARADA} estado_t;

    estado_t           estado;
    logic [BAUD_W-1:0] baud;
    logic [2:0]        bit_idx;
    logic [6:0]        shift;
    logic              listo;

    logic       p1, p2, p3;
    logic [6:0] codigo;
    logic [6:0] mascara;
    logic [6:0] palabra_nueva;

    // Index = Hamming position - 1, so a syndrome points straight at the flipped bit.
    always_comb begin
        p1 = bus.dato_i[0] ^ bus.dato_i[1] ^ bus.dato_i[3];
        p2 = bus.dato_i[0] ^ bus.dato_i[2] ^ bus.dato_i[3];
        p3 = bus.dato_i[1] ^ bus.dato_i[2] ^ bus.dato_i[3];
        codigo = {bus.dato_i[3], bus.dato_i[2], bus.dato_i[1], p3, bus.dato_i[0], p2, p1};
        mascara = '0;
        if (bus.error_pos_i != 3'd0)
            mascara = 7'b1 << (bus.error_pos_i - 3'd1);
        palabra_nueva = codigo ^ mascara;
    end

    assign bus.listo_o = listo;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            estado    <= REPOSO;
            baud      <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            palabra_o <= '0;
            tx_o      <= 1'b1;
            listo     <= 1'b1;
            ocupado_o <= 1'b0;
            hecho_o   <= 1'b0;
        end else begin
            hecho_o <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (bus.valido_i && listo) begin
                        palabra_o <= palabra_nueva;
                        shift     <= palabra_nueva;
                        estado    <= INICIO;
                        baud      <= '0;
                        tx_o      <= 1'b0;
                        listo     <= 1'b0;
                        ocupado_o <= 1'b1;
                    end
                end
                INICIO: begin
                    if (baud == BAUD_ULT) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        estado  <= DATOS;
                        tx_o    <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATOS: begin
                    if (baud == BAUD_ULT) begin
                        baud <= '0;
                        if (bit_idx == 3'd6) begin
                            estado <= PARADA;
                            tx_o   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= {1'b0, shift[6:1]};
                            tx_o    <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                PARADA: begin
                    if (baud == BAUD_ULT) begin
                        baud      <= '0;
                        estado    <= REPOSO;
                        listo     <= 1'b1;
                        ocupado_o <= 1'b0;
                        hecho_o   <= 1'b1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    estado <= REPOSO;
                    tx_o   <= 1'b1;
                    listo  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hamming_tx_serial.sv
// tb/tb_hamming_tx_serial.sv - directed checks of encoding, error injection and serial framing
module tb_hamming_tx_serial;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] palabra, palabra1;
    logic       tx, ocupado, hecho;
    logic       tx1, ocupado1, hecho1;

    int checks = 0;
    int errors = 0;

    hamming_tx_serial_if bus ();
    hamming_tx_serial_if bus1 ();

    hamming_tx_serial #(.CICLOS_POR_BIT(4)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus.slave),
        .palabra_o(palabra), .tx_o(tx), .ocupado_o(ocupado), .hecho_o(hecho)
    );

    hamming_tx_serial #(.CICLOS_POR_BIT(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .bus(bus1.slave),
        .palabra_o(palabra1), .tx_o(tx1), .ocupado_o(ocupado1), .hecho_o(hecho1)
    );

    always #5 clk = ~clk;

    logic [6:0] tabla [16] = '{
        7'b0000000, 7'b0000111, 7'b0011001, 7'b0011110,
        7'b0101010, 7'b0101101, 7'b0110011, 7'b0110100,
        7'b1001011, 7'b1001100, 7'b1010010, 7'b1010101,
        7'b1100001, 7'b1100110, 7'b1111000, 7'b1111111
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] sindrome(input logic [6:0] c);
        return {c[3] ^ c[4] ^ c[5] ^ c[6], c[1] ^ c[2] ^ c[5] ^ c[6], c[0] ^ c[2] ^ c[4] ^ c[6]};
    endfunction

    function automatic logic tx_esperado(input int c, input logic [6:0] w);
        if (c < 4) return 1'b0;
        if (c < 32) return w[(c - 4) / 4];
        return 1'b1;
    endfunction

    task automatic wait_listo();
        for (int i = 0; i < 100 && bus.listo_o !== 1'b1; i++) step();
        check("listo_wait", bus.listo_o, 1);
    endtask

    task automatic run_frame(input logic [3:0] d, input logic [2:0] e, input logic [6:0] w);
        int hecho_temprano;
        int tx_malos;
        hecho_temprano = 0;
        tx_malos = 0;
        wait_listo();
        bus.dato_i = d;
        bus.error_pos_i = e;
        bus.valido_i = 1'b1;
        step();
        bus.valido_i = 1'b0;
        check("palabra", palabra, w);
        check("ocupado_in_frame", ocupado, 1);
        check("sindrome", sindrome(palabra), e);
        for (int c = 0; c < 36; c++) begin
            if (tx !== tx_esperado(c, w)) begin
                tx_malos++;
                check($sformatf("tx_c%0d", c), tx, tx_esperado(c, w));
            end
            if (hecho !== 1'b0) hecho_temprano++;
            step();
        end
        check("tx_bits_wrong", tx_malos, 0);
        check("hecho_early", hecho_temprano, 0);
        check("hecho_at_36", hecho, 1);
        check("listo_at_36", bus.listo_o, 1);
        step();
        check("hecho_one_cycle", hecho, 0);
    endtask

    initial begin
        int pulsos;
        bus.dato_i = 4'b1011;
        bus.error_pos_i = 3'd0;
        bus.valido_i = 1'b1;
        bus1.dato_i = 4'b0;
        bus1.error_pos_i = 3'd0;
        bus1.valido_i = 1'b0;

        // reset held with valido high: reset must win
        rst = 1'b1;
        step();
        step();
        check("rst_tx", tx, 1);
        check("rst_listo", bus.listo_o, 1);
        check("rst_ocupado", ocupado, 0);
        check("rst_hecho", hecho, 0);
        check("rst_palabra", palabra, 0);
        bus.valido_i = 1'b0;
        rst = 1'b0;
        step();
        check("idle_tx", tx, 1);
        check("idle_palabra", palabra, 0);

        run_frame(4'b1011, 3'd0, 7'b1010101);

        for (int n = 0; n < 16; n++)
            run_frame(4'(n), 3'd0, tabla[n]);

        run_frame(4'b1011, 3'd3, 7'b1010001);
        for (int k = 1; k < 8; k++)
            run_frame(4'b1011, 3'(k), 7'b1010101 ^ (7'b1 << (k - 1)));

        // back-to-back with valido held high
        wait_listo();
        bus.dato_i = 4'b0001;
        bus.error_pos_i = 3'd0;
        bus.valido_i = 1'b1;
        step();
        check("b2b_first", palabra, 7'b0000111);
        for (int c = 0; c < 36; c++) begin
            if (c == 5) bus.dato_i = 4'b0010;
            if (c == 20) check("b2b_ignored", palabra, 7'b0000111);
            step();
        end
        check("b2b_hecho", hecho, 1);
        check("b2b_tx_stop", tx, 1);
        step();
        bus.valido_i = 1'b0;
        check("b2b_second", palabra, 7'b0011001);
        check("b2b_start", tx, 0);
        check("b2b_busy", bus.listo_o, 0);
        check("b2b_hecho_drop", hecho, 0);
        pulsos = 0;
        for (int c = 1; c < 37; c++) begin
            if (c == 5) check("b2b_d0", tx, 1);
            if (c == 9) check("b2b_d1", tx, 0);
            if (hecho === 1'b1) pulsos++;
            step();
        end
        check("b2b_hecho2", hecho, 1);
        check("b2b_hecho2_once", pulsos, 0);

        // reset mid-frame
        step();
        bus.dato_i = 4'b1111;
        bus.valido_i = 1'b1;
        step();
        bus.valido_i = 1'b0;
        check("mid_palabra", palabra, 7'b1111111);
        for (int c = 0; c < 15; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_listo", bus.listo_o, 1);
        check("mid_rst_ocupado", ocupado, 0);
        check("mid_rst_hecho", hecho, 0);
        check("mid_rst_palabra", palabra, 0);
        pulsos = 0;
        for (int c = 0; c < 40; c++) begin
            if (hecho === 1'b1) pulsos++;
            step();
        end
        check("mid_no_hecho", pulsos, 0);
        run_frame(4'b1011, 3'd0, 7'b1010101);

        // single-cycle bits
        bus1.dato_i = 4'b1011;
        bus1.valido_i = 1'b1;
        step();
        bus1.valido_i = 1'b0;
        check("n1_palabra", palabra1, 7'b1010101);
        for (int c = 0; c < 9; c++) begin
            check($sformatf("n1_tx_c%0d", c), tx1, (c == 0) ? 1'b0 : (c == 8) ? 1'b1 : ((c % 2) == 1));
            check($sformatf("n1_hecho_c%0d", c), hecho1, 0);
            step();
        end
        check("n1_hecho", hecho1, 1);
        check("n1_listo", bus1.listo_o, 1);
        check("n1_ocupado", ocupado1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
